// File: rtl/xosera_host_bus.sv
// rtl/xosera_host_bus.sv - host-side initiator for the Xosera 8-bit register bus
// Byte-cycle sequencer with programmable setup/strobe/hold plus a synchronised sticky interrupt flag.
module xosera_host_bus #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic        req_byte_i,
  input  logic        req_bytesel_i,
  input  logic [3:0]  req_reg_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_intr_i,
  output logic        intr_pending_o,
  input  logic        intr_ack_i
);

  localparam int MAX_ST = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CYC = (MAX_ST > HOLD_CYC) ? MAX_ST : HOLD_CYC;
  localparam int CW = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t      state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic        wr_q, wr_nx;
  logic        byte_q, byte_nx;
  logic [7:0]  odd_q, odd_nx;

  logic        ready_nx;
  logic        rsp_valid_nx;
  logic [15:0] rsp_data_nx;
  logic        cs_n_nx;
  logic        rd_nwr_nx;
  logic [3:0]  reg_num_nx;
  logic        bytesel_nx;
  logic [7:0]  bdata_nx;
  logic        oe_nx;

  logic        intr_s1, intr_s2, intr_s3;
  logic        intr_edge;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      wr_q          <= 1'b0;
      byte_q        <= 1'b0;
      odd_q         <= 8'h00;
      req_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= 16'h0000;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_reg_num_o <= 4'h0;
      bus_bytesel_o <= 1'b0;
      bus_data_o    <= 8'h00;
      bus_data_oe_o <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      wr_q          <= wr_nx;
      byte_q        <= byte_nx;
      odd_q         <= odd_nx;
      req_ready_o   <= ready_nx;
      rsp_valid_o   <= rsp_valid_nx;
      rsp_data_o    <= rsp_data_nx;
      bus_cs_n_o    <= cs_n_nx;
      bus_rd_nwr_o  <= rd_nwr_nx;
      bus_reg_num_o <= reg_num_nx;
      bus_bytesel_o <= bytesel_nx;
      bus_data_o    <= bdata_nx;
      bus_data_oe_o <= oe_nx;
    end
  end

  // Outputs are computed one state ahead so every bus pin comes straight from a flop.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    wr_nx        = wr_q;
    byte_nx      = byte_q;
    odd_nx       = odd_q;
    ready_nx     = req_ready_o;
    rsp_valid_nx = 1'b0;
    rsp_data_nx  = rsp_data_o;
    cs_n_nx      = bus_cs_n_o;
    rd_nwr_nx    = bus_rd_nwr_o;
    reg_num_nx   = bus_reg_num_o;
    bytesel_nx   = bus_bytesel_o;
    bdata_nx     = bus_data_o;
    oe_nx        = bus_data_oe_o;

    case (state)
      ST_IDLE: begin
        ready_nx = 1'b1;
        if (req_valid_i && req_ready_o) begin
          state_nx    = ST_SETUP;
          cnt_nx      = SETUP_LD;
          wr_nx       = req_wr_i;
          byte_nx     = req_byte_i;
          odd_nx      = req_data_i[7:0];
          ready_nx    = 1'b0;
          rsp_data_nx = 16'h0000;
          cs_n_nx     = 1'b1;
          rd_nwr_nx   = ~req_wr_i;
          reg_num_nx  = req_reg_i;
          oe_nx       = req_wr_i;
          bytesel_nx  = req_byte_i ? req_bytesel_i : 1'b0;
          if (!req_wr_i)
            bdata_nx = 8'h00;
          else if (req_byte_i && req_bytesel_i)
            bdata_nx = req_data_i[7:0];
          else
            bdata_nx = req_data_i[15:8];
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nx = ST_STROBE;
          cnt_nx   = STROBE_LD;
          cs_n_nx  = 1'b0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt == '0) begin
          state_nx = ST_HOLD;
          cnt_nx   = HOLD_LD;
          cs_n_nx  = 1'b1;
          if (!wr_q) begin
            if (bus_bytesel_o)
              rsp_data_nx[7:0] = bus_data_i;
            else
              rsp_data_nx[15:8] = bus_data_i;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          // A word always starts on the even lane, so lane 0 here means the odd byte is still owed.
          if (!byte_q && !bus_bytesel_o) begin
            state_nx   = ST_SETUP;
            cnt_nx     = SETUP_LD;
            bytesel_nx = 1'b1;
            bdata_nx   = wr_q ? odd_q : 8'h00;
          end else begin
            state_nx     = ST_DONE;
            rsp_valid_nx = 1'b1;
            oe_nx        = 1'b0;
            rd_nwr_nx    = 1'b1;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        ready_nx = 1'b1;
      end
      default: begin
        state_nx = ST_IDLE;
        ready_nx = 1'b1;
      end
    endcase
  end

  assign intr_edge = intr_s2 & ~intr_s3;

  // A fresh edge beats a simultaneous ack so no interrupt is ever lost.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      intr_s1        <= 1'b0;
      intr_s2        <= 1'b0;
      intr_s3        <= 1'b0;
      intr_pending_o <= 1'b0;
    end else begin
      intr_s1 <= bus_intr_i;
      intr_s2 <= intr_s1;
      intr_s3 <= intr_s2;
      if (intr_edge)
        intr_pending_o <= 1'b1;
      else if (intr_ack_i)
        intr_pending_o <= 1'b0;
    end
  end

endmodule
